// File: rtl/fft64_out_serializer.sv
// fft64_out_serializer: captures a parallel FFT frame on done and
// streams it out one bin per beat over a valid/ready interface.
module fft64_out_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done,
    input  logic [DATA_WIDTH-1:0]       din_real [N_POINTS],
    input  logic [DATA_WIDTH-1:0]       din_imag [N_POINTS],
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_real,
    output logic [DATA_WIDTH-1:0]       m_imag,
    output logic [$clog2(N_POINTS)-1:0] m_index,
    output logic                        m_last,
    output logic                        busy,
    output logic [7:0]                  drop_cnt,
    output logic                        overflow
);

    localparam int IW = $clog2(N_POINTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           rd_idx_q, rd_idx_d;
    logic [7:0]              drop_q, drop_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [IW-1:0]           index_q, index_d;
    logic [DATA_WIDTH-1:0]   re_q, re_d;
    logic [DATA_WIDTH-1:0]   im_q, im_d;
    logic [DATA_WIDTH-1:0]   fr_re_q [N_POINTS];
    logic [DATA_WIDTH-1:0]   fr_im_q [N_POINTS];

    logic capture;
    logic drop;
    logic xfer;
    logic at_last;

    // Next-state, drop accounting and the registered beat for the next cycle
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        capture  = 1'b0;
        drop     = 1'b0;
        xfer     = (state_q == STREAM) && m_ready;
        at_last  = (rd_idx_q == LAST_IDX);

        unique case (state_q)
            IDLE: begin
                if (done) begin
                    capture = 1'b1;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    // A new frame landing on the final transfer chains seamlessly
                    if (done) begin
                        capture = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        rd_idx_d = '0;
                    end
                end else begin
                    if (xfer) begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                    if (done) begin
                        drop = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                rd_idx_d = '0;
            end
        endcase

        if (capture) begin
            state_d  = STREAM;
            rd_idx_d = '0;
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        valid_d = (state_d == STREAM);
        index_d = valid_d ? rd_idx_d : '0;
        last_d  = valid_d && (rd_idx_d == LAST_IDX);
        re_d    = '0;
        im_d    = '0;
        if (valid_d) begin
            re_d = capture ? din_real[rd_idx_d] : fr_re_q[rd_idx_d];
            im_d = capture ? din_imag[rd_idx_d] : fr_im_q[rd_idx_d];
        end
    end

    // Control state and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_idx_q <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            index_q  <= '0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            index_q  <= index_d;
            re_q     <= re_d;
            im_q     <= im_d;
        end
    end

    // Frame buffer is only written on capture; reset leaves it as-is
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            fr_re_q <= din_real;
            fr_im_q <= din_imag;
        end
    end

    assign m_valid  = valid_q;
    assign m_last   = last_q;
    assign m_index  = index_q;
    assign m_real   = re_q;
    assign m_imag   = im_q;
    assign busy     = (state_q == STREAM);
    assign drop_cnt = drop_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fft64_out_serializer.sv
// tb_fft64_out_serializer: scoreboard bench; stimulus pushes expected
// beats, a negedge monitor pops and compares on every transfer.
module tb_fft64_out_serializer;

    localparam int DW = 16;
    localparam int NP = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done = 1'b0;
    logic [DW-1:0] din_real [NP];
    logic [DW-1:0] din_imag [NP];
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_real;
    logic [DW-1:0] m_imag;
    logic [5:0]    m_index;
    logic          m_last;
    logic          busy;
    logic [7:0]    drop_cnt;
    logic          overflow;

    typedef struct {
        int            idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } beat_t;

    beat_t sb[$];

    int  n_vec = 0;
    int  n_err = 0;
    int  n_xfer = 0;
    bit  rand_rdy = 1'b0;
    bit  fix_rdy = 1'b1;

    bit            p_stall = 1'b0;
    logic [DW-1:0] p_re, p_im;
    logic [5:0]    p_idx;
    logic          p_last;

    fft64_out_serializer #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
        .clk(clk), .rst(rst), .done(done),
        .din_real(din_real), .din_imag(din_imag),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_last(m_last),
        .busy(busy), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: stall stability, then scoreboard compare on transfer
    always @(negedge clk) begin
        if (p_stall) begin
            n_vec++;
            if (!m_valid || m_real !== p_re || m_imag !== p_im ||
                m_index !== p_idx || m_last !== p_last) begin
                n_err++;
                $display("FAIL stall_hold: got v=%0b i=%0d re=%h im=%h l=%0b expected v=1 i=%0d re=%h im=%h l=%0b",
                         m_valid, m_index, m_real, m_imag, m_last,
                         p_idx, p_re, p_im, p_last);
            end
        end
        if (m_valid && m_ready) begin
            n_xfer++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL beat_extra: got beat idx %0d expected none", m_index);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (int'(m_index) != e.idx || m_real !== e.re ||
                    m_imag !== e.im || m_last !== e.last) begin
                    n_err++;
                    $display("FAIL beat: got i=%0d re=%h im=%h l=%0b expected i=%0d re=%h im=%h l=%0b",
                             m_index, m_real, m_imag, m_last,
                             e.idx, e.re, e.im, e.last);
                end
            end
        end
        p_stall = m_valid && !m_ready;
        p_re    = m_real;
        p_im    = m_imag;
        p_idx   = m_index;
        p_last  = m_last;
    end

    task automatic load(input int base);
        for (int k = 0; k < NP; k++) begin
            din_real[k] = DW'(base + k);
            din_imag[k] = DW'(-(base + k));
        end
    endtask

    task automatic push_frame(input int base);
        beat_t b;
        for (int k = 0; k < NP; k++) begin
            b.idx  = k;
            b.re   = DW'(base + k);
            b.im   = DW'(-(base + k));
            b.last = (k == NP - 1);
            sb.push_back(b);
        end
    endtask

    // Issue a captured frame; returns at #1 after the sampling edge
    task automatic send(input int base);
        load(base);
        push_frame(base);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL idle_timeout: got busy after %0d cycles expected idle", cyc);
                break;
            end
        end
    endtask

    task automatic wait_index(input int idx);
        int n;
        n = 0;
        while (!(m_valid && int'(m_index) == idx)) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL index_timeout: got index %0d expected %0d", m_index, idx);
                break;
            end
        end
    endtask

    initial begin
        int c;
        int x0;
        load(0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", m_last, 0);
        chk("rst_index", m_index, 0);
        chk("rst_real", m_real, 0);
        chk("rst_imag", m_imag, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);

        // Single frame, ready tied high
        fix_rdy = 1'b1;
        @(posedge clk);
        #1;
        send(0);
        @(negedge clk);
        chk("lat_valid", m_valid, 1);
        chk("lat_index", m_index, 0);
        wait_idle(c);
        chk("single_len", c, 63);
        chk("single_valid_off", m_valid, 0);

        // Random backpressure
        rand_rdy = 1'b1;
        x0 = n_xfer;
        @(posedge clk);
        #1;
        send(100);
        wait_idle(c);
        chk("bp_xfers", n_xfer - x0, 64);
        chk("bp_sb_empty", sb.size(), 0);
        rand_rdy = 1'b0;

        // Drop while busy at beat 10
        fix_rdy = 1'b1;
        @(posedge clk);
        #1;
        send(200);
        wait_index(10);
        load(900);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        wait_idle(c);
        repeat (4) @(negedge clk);
        chk("drop_cnt", drop_cnt, 1);
        chk("drop_ovf", overflow, 1);
        chk("drop_busy", busy, 0);
        chk("drop_sb_empty", sb.size(), 0);

        // Reset mid-stream at beat 20
        @(posedge clk);
        #1;
        send(300);
        wait_index(20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mrst_valid", m_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_drop", drop_cnt, 0);
        chk("mrst_ovf", overflow, 0);
        @(posedge clk);
        #1;
        send(400);
        @(negedge clk);
        chk("mrst_restart_idx", m_index, 0);
        wait_idle(c);
        chk("mrst_len", c, 63);

        // Seamless chaining of A then B
        @(posedge clk);
        #1;
        send(500);
        repeat (64) @(negedge clk);
        chk("chain_a_last", m_index, 63);
        load(600);
        push_frame(600);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        wait_idle(c);
        chk("chain_b_len", c, 64);
        chk("chain_drop", drop_cnt, 0);

        // Drop counter saturation while stalled
        fix_rdy = 1'b0;
        @(posedge clk);
        #1;
        send(700);
        done = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        done = 1'b0;
        @(negedge clk);
        chk("sat_cnt", drop_cnt, 255);
        chk("sat_ovf", overflow, 1);
        chk("sat_busy", busy, 1);
        chk("sat_idx", m_index, 0);
        done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        done = 1'b0;
        @(negedge clk);
        chk("sat_hold", drop_cnt, 255);
        fix_rdy = 1'b1;
        wait_idle(c);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
